// File: rtl/lut_sweep_controller.sv
// lut_sweep_controller: sweeps one LUT row across all columns, LANES reads per
// clock over BRAM_COUNT banks, and accumulates a signed sum. Optional macro: LUT_SWEEP_SATURATE_EN.
module lut_sweep_controller #(
    parameter int X_ENC_SIZE      = 3,
    parameter int I_SIZE          = 1,
    parameter int J_SIZE          = 2,
    parameter int LANES_SIZE      = 1,
    parameter int BRAM_COUNT_SIZE = 1,
    parameter int RAM_WIDTH       = 8,
    parameter int ACC_WIDTH       = RAM_WIDTH + J_SIZE,
    parameter int ADDR_SIZE       = I_SIZE + J_SIZE - BRAM_COUNT_SIZE + X_ENC_SIZE,
    parameter int BRAM_COUNT      = 1 << BRAM_COUNT_SIZE
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [X_ENC_SIZE-1:0]             x_enc,
    input  logic [I_SIZE-1:0]                 i,
    output logic                              busy,
    output logic [BRAM_COUNT-1:0]             bram_en,
    output logic [BRAM_COUNT*ADDR_SIZE-1:0]   bram_addr,
    input  logic [BRAM_COUNT*RAM_WIDTH-1:0]   bram_data,
    output logic [ACC_WIDTH-1:0]              result,
    output logic                              result_valid,
    input  logic                              result_ready
);

    localparam int LANES  = 1 << LANES_SIZE;
    localparam int ISSUES = 1 << (J_SIZE - LANES_SIZE);
    localparam int KW     = (J_SIZE > LANES_SIZE) ? (J_SIZE - LANES_SIZE) : 1;
    localparam int SW     = ACC_WIDTH + LANES_SIZE + 1;
    localparam int HI_SH  = J_SIZE - BRAM_COUNT_SIZE + X_ENC_SIZE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LUT_SWEEP_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`endif

    logic [1:0]                  state_q;
    logic [KW-1:0]               k_q;
    logic [X_ENC_SIZE-1:0]       x_q;
    logic [I_SIZE-1:0]           i_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        pend_q;
    logic [BRAM_COUNT_SIZE-1:0]  base_q;

    logic [BRAM_COUNT_SIZE-1:0]  cur_base;
    logic signed [SW-1:0]        lane_sum;
    logic signed [SW-1:0]        acc_sum;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign result       = acc_q;

    // Bank enables and addresses for the current issue; lanes land on distinct banks.
    always_comb begin : issue_decode
        logic [J_SIZE-1:0]    j;
        logic [J_SIZE-1:0]    jb;
        logic [ADDR_SIZE-1:0] a;
        bram_en   = '0;
        bram_addr = '0;
        cur_base  = '0;
        j         = '0;
        jb        = '0;
        a         = '0;
        if (state_q == S_ISSUE) begin
            jb       = J_SIZE'(k_q) << LANES_SIZE;
            cur_base = jb[BRAM_COUNT_SIZE-1:0];
            for (int l = 0; l < LANES; l++) begin
                j = jb | J_SIZE'(l);
                a = (ADDR_SIZE'(i_q) << HI_SH)
                  | (ADDR_SIZE'(j >> BRAM_COUNT_SIZE) << X_ENC_SIZE)
                  | ADDR_SIZE'(x_q);
                bram_en[j[BRAM_COUNT_SIZE-1:0]] = 1'b1;
                bram_addr[j[BRAM_COUNT_SIZE-1:0]*ADDR_SIZE +: ADDR_SIZE] = a;
            end
        end
    end

    // Sum the lanes returned for the previous issue and form the next accumulator.
    always_comb begin : lane_accum
        logic [RAM_WIDTH-1:0] v;
        v        = '0;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            v = bram_data[(int'(base_q) + l)*RAM_WIDTH +: RAM_WIDTH];
            lane_sum = lane_sum + SW'($signed(v));
        end
        acc_sum = SW'(acc_q) + lane_sum;
`ifdef LUT_SWEEP_SATURATE_EN
        if (acc_sum > SAT_MAX)
            acc_next = SAT_MAX[ACC_WIDTH-1:0];
        else if (acc_sum < SAT_MIN)
            acc_next = SAT_MIN[ACC_WIDTH-1:0];
        else
            acc_next = acc_sum[ACC_WIDTH-1:0];
`else
        acc_next = acc_sum[ACC_WIDTH-1:0];
`endif
    end

    // Sweep FSM: accept, issue reads, drain the last return, hold result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            pend_q  <= 1'b0;
            base_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pend_q <= 1'b0;
                    if (start) begin
                        x_q     <= x_enc;
                        i_q     <= i;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pend_q)
                        acc_q <= acc_next;
                    pend_q <= 1'b1;
                    base_q <= cur_base;
                    k_q    <= k_q + 1'b1;
                    if (k_q == KW'(ISSUES - 1))
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pend_q)
                        acc_q <= acc_next;
                    pend_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: begin
                    pend_q <= 1'b0;
                    if (result_ready)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_sweep_controller.sv
// tb_lut_sweep_controller: directed checks of addressing, sums, latency,
// backpressure, reset and scaling for lut_sweep_controller.
module tb_lut_sweep_controller;

    logic clock;
    logic reset_n;

    logic        a_start, a_valid, a_ready, a_busy;
    logic [2:0]  a_x;
    logic [0:0]  a_i;
    logic [1:0]  a_en;
    logic [9:0]  a_addr;
    logic [15:0] a_data;
    logic [9:0]  a_res;
    logic [7:0]  a_val;

    logic        b_start, b_valid, b_ready, b_busy;
    logic [2:0]  b_x;
    logic [0:0]  b_i;
    logic [1:0]  b_en;
    logic [9:0]  b_addr;
    logic [15:0] b_data;
    logic [7:0]  b_res;

    logic        c_start, c_valid, c_ready, c_busy;
    logic [2:0]  c_x;
    logic [0:0]  c_i;
    logic [3:0]  c_en;
    logic [23:0] c_addr;
    logic [31:0] c_data;
    logic [11:0] c_res;

    int pass_cnt = 0;
    int total    = 0;

    lut_sweep_controller u_a (
        .clock(clock), .reset_n(reset_n), .start(a_start),
        .x_enc(a_x), .i(a_i), .busy(a_busy), .bram_en(a_en),
        .bram_addr(a_addr), .bram_data(a_data), .result(a_res),
        .result_valid(a_valid), .result_ready(a_ready)
    );

    lut_sweep_controller #(.ACC_WIDTH(8)) u_b (
        .clock(clock), .reset_n(reset_n), .start(b_start),
        .x_enc(b_x), .i(b_i), .busy(b_busy), .bram_en(b_en),
        .bram_addr(b_addr), .bram_data(b_data), .result(b_res),
        .result_valid(b_valid), .result_ready(b_ready)
    );

    lut_sweep_controller #(
        .J_SIZE(4), .LANES_SIZE(2), .BRAM_COUNT_SIZE(2)
    ) u_c (
        .clock(clock), .reset_n(reset_n), .start(c_start),
        .x_enc(c_x), .i(c_i), .busy(c_busy), .bram_en(c_en),
        .bram_addr(c_addr), .bram_data(c_data), .result(c_res),
        .result_valid(c_valid), .result_ready(c_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bank models: one-cycle read latency.
    always @(posedge clock) begin
        for (int b = 0; b < 2; b++) begin
            a_data[b*8 +: 8] <= a_en[b] ? a_val : 8'h00;
            b_data[b*8 +: 8] <= b_en[b] ? 8'd127 : 8'h00;
        end
        for (int b = 0; b < 4; b++) begin
            logic [1:0] bl;
            bl = 2'(b);
            c_data[b*8 +: 8] <= c_en[b] ? {4'h0, c_addr[b*6+3 +: 2], bl} : 8'h00;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_a(input logic [2:0] x, input logic [0:0] iv,
                         output int lat, output logic [9:0] res);
        a_x = x; a_i = iv; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        lat = 1;
        while (!a_valid && lat < 30) begin
            tick;
            lat++;
        end
        res = a_res;
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        tick;
        total++;
        if ({a_busy, a_en, a_addr, a_res, a_valid} !== 24'd0)
            $display("FAIL reset_a_outputs: got %h want 0",
                     {a_busy, a_en, a_addr, a_res, a_valid});
        else pass_cnt++;
        total++;
        if ({c_busy, c_en, c_addr, c_res, c_valid} !== 42'd0)
            $display("FAIL reset_c_outputs: got %h want 0",
                     {c_busy, c_en, c_addr, c_res, c_valid});
        else pass_cnt++;
        #2 reset_n = 1'b1;
        tick;
    endtask

    task automatic test_address_pattern;
        a_val = 8'd1; a_x = 3'b101; a_i = 1'b1;
        total++;
        if (a_en !== 2'b00) $display("FAIL addr_idle_en: got %b want 00", a_en);
        else pass_cnt++;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        a_x = 3'b010; a_i = 1'b0;
        total++;
        if (a_en !== 2'b11) $display("FAIL addr_issue0_en: got %b want 11", a_en);
        else pass_cnt++;
        total++;
        if (a_addr !== {5'd21, 5'd21})
            $display("FAIL addr_issue0: got %h want %h", a_addr, {5'd21, 5'd21});
        else pass_cnt++;
        tick;
        total++;
        if (a_en !== 2'b11) $display("FAIL addr_issue1_en: got %b want 11", a_en);
        else pass_cnt++;
        total++;
        if (a_addr !== {5'd29, 5'd29})
            $display("FAIL addr_issue1: got %h want %h", a_addr, {5'd29, 5'd29});
        else pass_cnt++;
        tick;
        total++;
        if ({a_en, a_addr} !== 12'd0)
            $display("FAIL addr_drain: got %h want 0", {a_en, a_addr});
        else pass_cnt++;
        tick;
        total++;
        if (a_valid !== 1'b1 || a_res !== 10'd4)
            $display("FAIL addr_result: got v=%b r=%0d want v=1 r=4", a_valid, a_res);
        else pass_cnt++;
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
    endtask

    task automatic test_sum_latency;
        int lat;
        logic [9:0] res;
        a_val = 8'd1;
        run_a(3'd0, 1'b0, lat, res);
        total++;
        if (lat != 4) $display("FAIL latency_ones: got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if (res !== 10'd4) $display("FAIL sum_ones: got %0d want 4", res);
        else pass_cnt++;
        a_val = 8'hFD;
        run_a(3'd6, 1'b1, lat, res);
        total++;
        if (res !== 10'h3F4) $display("FAIL sum_neg3: got %h want 3f4", res);
        else pass_cnt++;
        total++;
        if (a_busy !== 1'b0) $display("FAIL busy_after: got %b want 0", a_busy);
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        int lat;
        logic [7:0] exp_r;
`ifdef LUT_SWEEP_SATURATE_EN
        exp_r = 8'd127;
`else
        exp_r = 8'hFC;
`endif
        b_x = 3'd1; b_i = 1'b0; b_start = 1'b1;
        tick;
        b_start = 1'b0;
        lat = 1;
        while (!b_valid && lat < 30) begin
            tick;
            lat++;
        end
        total++;
        if (b_res !== exp_r) $display("FAIL overflow: got %h want %h", b_res, exp_r);
        else pass_cnt++;
        b_ready = 1'b1;
        tick;
        b_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        logic [9:0] held;
        a_val = 8'd2; a_x = 3'd3; a_i = 1'b0; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        n = 0;
        while (!a_valid && n < 30) begin
            tick;
            n++;
        end
        total++;
        if (a_valid !== 1'b1) $display("FAIL bp_reach_done: got %b want 1", a_valid);
        else pass_cnt++;
        held = a_res;
        total++;
        if (held !== 10'd8) $display("FAIL bp_result: got %0d want 8", held);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            a_start = c[0];
            tick;
            total++;
            if (a_res !== 10'd8 || a_en !== 2'b00 || a_busy !== 1'b1 || a_valid !== 1'b1)
                $display("FAIL bp_hold%0d: got r=%0d en=%b busy=%b v=%b want r=8 en=00 busy=1 v=1",
                         c, a_res, a_en, a_busy, a_valid);
            else pass_cnt++;
        end
        a_ready = 1'b1; a_start = 1'b1;
        tick;
        total++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0)
            $display("FAIL bp_release: got busy=%b v=%b want 0 0", a_busy, a_valid);
        else pass_cnt++;
        a_ready = 1'b0;
        tick;
        a_start = 1'b0;
        total++;
        if (a_busy !== 1'b1 || a_en !== 2'b11)
            $display("FAIL bp_restart: got busy=%b en=%b want 1 11", a_busy, a_en);
        else pass_cnt++;
        n = 0;
        while (!a_valid && n < 30) begin
            tick;
            n++;
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [9:0] res;
        a_val = 8'd5; a_x = 3'd2; a_i = 1'b1; a_start = 1'b1;
        tick;
        a_start = 1'b0;
        tick;
        total++;
        if (a_en !== 2'b11) $display("FAIL rst_pre_en: got %b want 11", a_en);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({a_busy, a_en, a_addr, a_res, a_valid} !== 24'd0)
            $display("FAIL rst_async: got %h want 0",
                     {a_busy, a_en, a_addr, a_res, a_valid});
        else pass_cnt++;
        tick;
        #2 reset_n = 1'b1;
        tick;
        a_val = 8'd2;
        run_a(3'd2, 1'b1, lat, res);
        total++;
        if (res !== 10'd8 || lat != 4)
            $display("FAIL rst_clean: got r=%0d lat=%0d want r=8 lat=4", res, lat);
        else pass_cnt++;
    endtask

    task automatic test_scaling;
        int lat;
        int issues;
        c_x = 3'd3; c_i = 1'b1; c_start = 1'b1;
        tick;
        c_start = 1'b0;
        lat = 1;
        issues = (c_en == 4'hF) ? 1 : 0;
        while (!c_valid && lat < 30) begin
            tick;
            lat++;
            if (c_en == 4'hF) issues++;
        end
        total++;
        if (c_res !== 12'd120) $display("FAIL scale_sum: got %0d want 120", c_res);
        else pass_cnt++;
        total++;
        if (lat != 6) $display("FAIL scale_latency: got %0d want 6", lat);
        else pass_cnt++;
        total++;
        if (issues != 4) $display("FAIL scale_issues: got %0d want 4", issues);
        else pass_cnt++;
        c_ready = 1'b1;
        tick;
        c_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic prev;
        int rise[$];
        int n;
        a_val = 8'd1; a_x = 3'd0; a_i = 1'b0;
        a_start = 1'b1; a_ready = 1'b1;
        prev = a_busy;
        for (int c = 0; c < 16; c++) begin
            tick;
            if (a_busy && !prev) rise.push_back(c);
            if (a_valid) begin
                total++;
                if (a_res !== 10'd4) $display("FAIL b2b_result: got %0d want 4", a_res);
                else pass_cnt++;
            end
            prev = a_busy;
        end
        a_start = 1'b0;
        n = 0;
        while (a_busy && n < 30) begin
            tick;
            n++;
        end
        a_ready = 1'b0;
        total++;
        if (rise.size() < 2)
            $display("FAIL b2b_count: got %0d starts want >=2", rise.size());
        else if (rise[1] - rise[0] != 5)
            $display("FAIL b2b_period: got %0d want 5", rise[1] - rise[0]);
        else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b0;
        a_start = 0; a_ready = 0; a_x = 0; a_i = 0; a_val = 0;
        b_start = 0; b_ready = 0; b_x = 0; b_i = 0;
        c_start = 0; c_ready = 0; c_x = 0; c_i = 0;
        #1;
        test_reset;
        test_address_pattern;
        test_sum_latency;
        test_overflow;
        test_backpressure;
        test_reset_mid;
        test_scaling;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/lut_sweep_controller.md
# lut_sweep_controller

Parametrised successor to the single-lane matrix controller. It sweeps one matrix row `i` over all `2^J_SIZE` columns for an encoded input `x_enc`, issuing `LANES` LUT reads per clock across `BRAM_COUNT` banks. Returned values are accumulated into a signed sum, and the result is presented on a valid/ready output. It sits between the X encoder (which supplies `x_enc`) and the external BRAM banks (1-cycle read latency), replacing the hard-wired single-lane loop with an FSM that supports start, backpressure and reset.

## Interface
- `X_ENC_SIZE`, 3: width of the encoded input.
- `I_SIZE`, 1: row-index width (≥1).
- `J_SIZE`, 2: log2 of the column count.
- `LANES_SIZE`, 1: log2 of lanes per clock. Must satisfy `LANES_SIZE ≤ BRAM_COUNT_SIZE` and `LANES_SIZE ≤ J_SIZE`.
- `BRAM_COUNT_SIZE`, 1: log2 of the bank count. Must satisfy `BRAM_COUNT_SIZE ≤ J_SIZE`.
- `RAM_WIDTH`, 8: LUT entry width, signed two's complement.
- `ACC_WIDTH`, `RAM_WIDTH + J_SIZE`: accumulator and result width.
- `ADDR_SIZE`, derived as `I_SIZE + J_SIZE - BRAM_COUNT_SIZE + X_ENC_SIZE`: bank address width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request, sampled only in IDLE.
- `x_enc` in `X_ENC_SIZE`: encoded input, latched on accept.
- `i` in `I_SIZE`: row index, latched on accept.
- `busy` out 1: high in every state except IDLE.
- `bram_en` out `BRAM_COUNT`: per-bank read enable.
- `bram_addr` out `BRAM_COUNT*ADDR_SIZE`: flattened bank addresses; bank b occupies bits `[b*ADDR_SIZE +: ADDR_SIZE]`.
- `bram_data` in `BRAM_COUNT*RAM_WIDTH`: flattened bank read data, valid the cycle after `bram_en`.
- `result` out `ACC_WIDTH`: signed sum of all looked-up entries.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.

## Operation
- Derived constants: `LANES = 2^LANES_SIZE`, `ISSUES = 2^(J_SIZE-LANES_SIZE)`.
- Column of lane l at issue k: `j = k*LANES + l`.
- Address mapping for column j:
  - bank = `j[BRAM_COUNT_SIZE-1:0]`
  - addr = `{i, j[J_SIZE-1:BRAM_COUNT_SIZE], x_enc}`
  - Lanes in the same issue always hit distinct banks, so no arbitration is needed.
- FSM states IDLE, ISSUE, DRAIN, DONE:
  - IDLE: when `start`=1, latch `x_enc` and `i`, clear the accumulator and issue counter `k`, then go to ISSUE.
  - ISSUE: drive the enables and addresses for issue k. Accumulate the lane data returned for issue k-1 (nothing is accumulated when k=0). Increment k. After issue `ISSUES-1`, go to DRAIN.
  - DRAIN: accumulate the data of the last issue, then go to DONE.
  - DONE: `result_valid`=1. On `result_ready`=1, go to IDLE.
- Bank signals:
  - Banks not addressed in a cycle have `bram_en`=0 and `bram_addr` driven to 0.
  - Outside ISSUE, all `bram_en` and `bram_addr` are 0.
- Arithmetic:
  - Each lane value is sign-extended to `ACC_WIDTH`.
  - The per-cycle lane sum is added to the accumulator.
  - Overflow behaviour is set under Configuration.
- Boundary and concurrency rules:
  - `start` outside IDLE is ignored.
  - Changes on `x_enc` or `i` after accept have no effect on the sweep in progress.
  - `start` in the same cycle as the DONE→IDLE handshake is not accepted; the earliest accept is the next cycle.
- Reset (asserted at any time, including mid-sweep):
  - State returns to IDLE; accumulator and k are cleared.
  - All outputs are 0 while reset is held: `busy`, `bram_en`, `bram_addr`, `result`, `result_valid`.
  - Data returning from an in-flight read is discarded.

## Timing
- Start accepted at edge 0 → ISSUE during cycles 1..ISSUES → DRAIN during cycle ISSUES+1 → `result_valid` rises after edge ISSUES+2.
- With defaults (ISSUES=2), `result_valid` is high 4 cycles after the accept edge.
- `result` is stable while `result_valid`=1 and `result_ready`=0. `result_valid` drops on the edge where `result_ready`=1 is sampled.
- Back-to-back sweeps: the minimum start-to-start period is ISSUES+3 cycles when `result_ready` is tied high.
- `busy` rises on the edge after the accept and falls on the edge of the DONE handshake.

## Configuration
- `LUT_SWEEP_SATURATE_EN`:
  - Defined: each accumulation clamps to the signed range `[-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]`. Clamping is applied after every cycle's add, and the clamped value is carried forward.
  - Undefined: the accumulator wraps modulo `2^ACC_WIDTH`.
  - At default `ACC_WIDTH`, overflow cannot occur, so both builds give identical results.

## Test plan
- Address pattern: defaults, `x_enc`=3'b101, `i`=1 → issue 0 drives bank0 and bank1 at addr 5'b10101 (21); issue 1 drives both at addr 5'b11101 (29); `bram_en`=2'b11 in both cycles and 2'b00 otherwise.
- Sum and latency: all LUT entries = 1 → `result`=4, `result_valid` high exactly 4 cycles after the start edge. All entries = −3 → `result`=−12.
- Overflow: `ACC_WIDTH`=8, all entries = 127:
  - Macro defined → `result`=127.
  - Macro undefined → `result`=8'hFC (−4).
- Backpressure: hold `result_ready`=0 for 5 cycles with `start` pulsing → `result` unchanged, no new `bram_en`, `busy`=1. Release → IDLE next cycle, then a new start is accepted.
- Reset mid-sweep: assert `reset_n`=0 during issue 1 → all outputs 0 immediately (asynchronous). After release plus `start`, the next result equals a clean sweep, with no residue from the aborted sweep.
- Scaling: `J_SIZE`=4, `LANES_SIZE`=2, `BRAM_COUNT_SIZE`=2, entries = column index j → `result`=120, 4 issue cycles, `result_valid` high 6 cycles after start.
